hci_mem_mux_switch: RTL

- Parametrised N-to-1 HCI memory-side multiplexer with a software-style channel select, for ports that are used strictly one at a time.
- Unlike a purely combinational static mux, it switches safely. A select change is held off until every transaction already issued on the active channel has received its response.
- Each response is routed to the channel that issued the request. Optionally, the number of in-flight transactions is capped.
- Sits between accelerator/streamer ports and a single TCDM/memory port.

---
 rtl/hci_mem_mux_switch.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/hci_mem_mux_switch.sv
// N-to-1 HCI memory-side mux with a drained channel switch.
// A select change waits until every issued transaction has been answered.

package hci_package;
    localparam int unsigned DEFAULT_DW = 32;
    localparam int unsigned DEFAULT_AW = 32;
    localparam int unsigned DEFAULT_BW = 8;
    localparam int unsigned DEFAULT_UW = 1;
endpackage

interface hci_mem_intf #(
    parameter int unsigned DW = hci_package::DEFAULT_DW,
    parameter int unsigned AW = hci_package::DEFAULT_AW,
    parameter int unsigned BW = hci_package::DEFAULT_BW,
    parameter int unsigned UW = hci_package::DEFAULT_UW,
    parameter int unsigned IW = 10
) ();
    logic              req;
    logic              gnt;
    logic [AW-1:0]     add;
    logic              wen;
    logic [DW-1:0]     data;
    logic [DW/BW-1:0]  be;
    logic [UW-1:0]     user;
    logic [IW-1:0]     id;
    logic [DW-1:0]     r_data;
    logic              r_valid;
    logic [UW-1:0]     r_user;
    logic [IW-1:0]     r_id;

    modport master (
        output req, add, wen, data, be, user, id,
        input  gnt, r_data, r_valid, r_user, r_id
    );
    modport slave (
        input  req, add, wen, data, be, user, id,
        output gnt, r_data, r_valid, r_user, r_id
    );
endinterface

module hci_mem_mux_switch #(
    parameter int unsigned NB_CHAN         = 2,
    parameter int unsigned DW              = hci_package::DEFAULT_DW,
    parameter int unsigned AW              = hci_package::DEFAULT_AW,
    parameter int unsigned BW              = hci_package::DEFAULT_BW,
    parameter int unsigned UW              = hci_package::DEFAULT_UW,
    parameter int unsigned IW              = 10,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned SELW            = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       clear_i,
    input  logic [SELW-1:0]                            sel_i,
    output logic [SELW-1:0]                            active_sel_o,
    output logic                                       switching_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_o,
    hci_mem_intf.slave                                 in [NB_CHAN-1:0],
    hci_mem_intf.master                                out
);

    localparam int unsigned BEW = DW / BW;
    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        ACTIVE = 1'b0,
        DRAIN  = 1'b1
    } state_e;

    state_e          state_q;
    logic [SELW-1:0] active_sel_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_nxt;

    logic [NB_CHAN-1:0] req_a;
    logic [NB_CHAN-1:0] wen_a;
    logic [AW-1:0]      add_a  [NB_CHAN];
    logic [DW-1:0]      data_a [NB_CHAN];
    logic [BEW-1:0]     be_a   [NB_CHAN];
    logic [UW-1:0]      user_a [NB_CHAN];
    logic [IW-1:0]      id_a   [NB_CHAN];
    logic [NB_CHAN-1:0] gnt_a;
    logic [NB_CHAN-1:0] rvalid_a;

    logic sel_valid;
    logic switch_req;
    logic full;
    logic issue_en;
    logic grant;
    logic rv_eff;

    // Unpack the channel interfaces so the active channel can be picked by a
    // run-time index; responses data/id/user are broadcast, only r_valid is steered.
    for (genvar i = 0; i < NB_CHAN; i++) begin : g_chan
        assign req_a[i]       = in[i].req;
        assign wen_a[i]       = in[i].wen;
        assign add_a[i]       = in[i].add;
        assign data_a[i]      = in[i].data;
        assign be_a[i]        = in[i].be;
        assign user_a[i]      = in[i].user;
        assign id_a[i]        = in[i].id;
        assign in[i].gnt      = gnt_a[i];
        assign in[i].r_valid  = rvalid_a[i];
        assign in[i].r_data   = out.r_data;
        assign in[i].r_id     = out.r_id;
        assign in[i].r_user   = out.r_user;
    end

    assign sel_valid  = (32'(sel_i) < NB_CHAN);
    assign switch_req = sel_valid && (sel_i != active_sel_q);
    assign rv_eff     = out.r_valid && (cnt_q != '0);
    assign full       = (cnt_q == CW'(MAX_OUTSTANDING)) && !out.r_valid;

    // Issue is also stopped in the cycle a switch is requested, so the old
    // channel never picks up a grant once the select has moved away from it.
    assign issue_en   = rst_ni && (state_q == ACTIVE) && !switch_req && !full;

    assign out.req    = issue_en && req_a[active_sel_q];
    assign out.add    = add_a[active_sel_q];
    assign out.wen    = wen_a[active_sel_q];
    assign out.data   = data_a[active_sel_q];
    assign out.be     = be_a[active_sel_q];
    assign out.user   = user_a[active_sel_q];
    assign out.id     = id_a[active_sel_q];

    assign grant      = out.req && out.gnt;
    assign cnt_nxt    = cnt_q + CW'(grant) - CW'(rv_eff);

    always_comb begin
        gnt_a    = '0;
        rvalid_a = '0;
        for (int i = 0; i < NB_CHAN; i++) begin
            if (active_sel_q == SELW'(i)) begin
                gnt_a[i]    = issue_en && out.gnt;
                rvalid_a[i] = rst_ni && out.r_valid;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ACTIVE;
            active_sel_q <= '0;
            cnt_q        <= '0;
        end else if (clear_i) begin
            state_q      <= ACTIVE;
            active_sel_q <= sel_valid ? sel_i : '0;
            cnt_q        <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            case (state_q)
                ACTIVE: begin
                    if (switch_req) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Select went back (or out of range): resume the old channel at once.
                    if (!switch_req) begin
                        state_q <= ACTIVE;
                    end else if (cnt_nxt == '0) begin
                        state_q      <= ACTIVE;
                        active_sel_q <= sel_i;
                    end
                end
                default: state_q <= ACTIVE;
            endcase
        end
    end

    assign active_sel_o  = active_sel_q;
    assign switching_o   = (state_q == DRAIN);
    assign outstanding_o = cnt_q;

endmodule
